// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: colour in, raster counters, syncs and DAC colour out.
interface vga_timing_gen_if;
  logic [11:0] rgb_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_start;
  logic [15:0] frame_count;
  logic        hsync;
  logic        vsync;
  logic [11:0] vga_rgb;

  modport master (
    input  rgb_in,
    output x, y, video_on, frame_start, frame_count, hsync, vsync, vga_rgb
  );

  modport slave (
    output rgb_in,
    input  x, y, video_on, frame_start, frame_count, hsync, vsync, vga_rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, zero-latency x/y/video_on,
// PIPE_DLY-delayed active-low syncs and a blanked, registered DAC colour aligned with them.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_DLY = 1
) (
  input logic              clk,
  input logic              reset,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_pipe_dly
    $error("vga_timing_gen: PIPE_DLY=%0d outside 1..4", PIPE_DLY);
  end
  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 1023", H_TOTAL, V_TOTAL);
  end

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [15:0] frame_cnt;
  logic        h_last;
  logic        v_last;

  assign h_last = (h_cnt == H_LAST);
  assign v_last = (v_cnt == V_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      if (v_last) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  sync_t raw;

  always_comb begin
    raw.video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    raw.hsync    = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    raw.vsync    = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
  end

  sync_t pipe [PIPE_DLY];

  // NOTE: the delay stages are plain flops, so they are reset to idle; no stale sync pulse survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= SYNC_IDLE;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The colour register adds the last stage, so the gate taps one stage short of the sync outputs.
  logic gate_on;

  if (PIPE_DLY == 1) begin : g_gate_raw
    assign gate_on = raw.video_on;
  end else begin : g_gate_pipe
    assign gate_on = pipe[PIPE_DLY-2].video_on;
  end

  logic [11:0] rgb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= gate_on ? bus.rgb_in : 12'h000;
    end
  end

  assign bus.x           = h_cnt;
  assign bus.y           = v_cnt;
  assign bus.video_on    = raw.video_on;
  assign bus.frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign bus.frame_count = frame_cnt;
  assign bus.hsync       = pipe[PIPE_DLY-1].hsync;
  assign bus.vsync       = pipe[PIPE_DLY-1].vsync;
  assign bus.vga_rgb     = rgb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 16x11 raster with a two-clock sync delay.
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int P = 2;
  localparam int FRAME = HT * VT;          // 176

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DLY(P)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Raster model indexed by cycles since reset release; negative indices mean "still in reset".
  function automatic logic [9:0] m_h(input int k);
    return 10'(k % HT);
  endfunction

  function automatic logic [9:0] m_v(input int k);
    return 10'((k / HT) % VT);
  endfunction

  function automatic logic m_von(input int k);
    if (k < 0) return 1'b0;
    return (int'(m_h(k)) < HA) && (int'(m_v(k)) < VA);
  endfunction

  function automatic logic m_hs(input int k);
    if (k < 0) return 1'b1;
    return !((int'(m_h(k)) >= HA + HF) && (int'(m_h(k)) < HA + HF + HS));
  endfunction

  function automatic logic m_vs(input int k);
    if (k < 0) return 1'b1;
    return !((int'(m_v(k)) >= VA + VF) && (int'(m_v(k)) < VA + VF + VS));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rgb_in = 12'hFFF;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.x !== 10'd0) begin errors++; $display("FAIL rst_hold_x got=%0d exp=0", bus.x); end
    checks++; if (bus.y !== 10'd0) begin errors++; $display("FAIL rst_hold_y got=%0d exp=0", bus.y); end
    checks++; if (bus.video_on !== 1'b1) begin errors++; $display("FAIL rst_hold_video_on got=%b exp=1", bus.video_on); end
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL rst_hold_frame_start got=%b exp=1", bus.frame_start); end
    checks++; if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL rst_hold_frame_count got=%0d exp=0", bus.frame_count); end
    checks++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin errors++; $display("FAIL rst_hold_syncs got=%b%b exp=11", bus.hsync, bus.vsync); end
    checks++; if (bus.vga_rgb !== 12'h000) begin errors++; $display("FAIL rst_hold_rgb got=%h exp=000", bus.vga_rgb); end

    @(negedge clk);
    reset = 1'b0;
    n = 0;
    #1;
    checks++; if (bus.x !== 10'd0 || bus.y !== 10'd0) begin errors++; $display("FAIL rel_c0_xy got=%0d,%0d exp=0,0", bus.x, bus.y); end
    checks++; if (bus.frame_start !== 1'b1 || bus.video_on !== 1'b1) begin errors++; $display("FAIL rel_c0_flags got=%b%b exp=11", bus.frame_start, bus.video_on); end
    checks++; if (bus.vga_rgb !== 12'h000) begin errors++; $display("FAIL rel_c0_rgb got=%h exp=000", bus.vga_rgb); end
    step();
    checks++; if (bus.x !== 10'd1 || bus.frame_start !== 1'b0) begin errors++; $display("FAIL rel_c1 got=x%0d fs%b exp=x1 fs0", bus.x, bus.frame_start); end
    checks++; if (bus.vga_rgb !== 12'h000) begin errors++; $display("FAIL rel_c1_rgb got=%h exp=000", bus.vga_rgb); end
    step();
    checks++; if (bus.vga_rgb !== 12'hFFF) begin errors++; $display("FAIL rel_c2_rgb got=%h exp=fff", bus.vga_rgb); end
  endtask

  task automatic test_frame();
    int starts = 0;
    do_reset();
    bus.rgb_in = 12'h000;
    for (int i = 0; i <= FRAME; i++) begin
      if (i > 0) step();
      if (bus.frame_start === 1'b1) starts++;
      checks++;
      if (bus.x !== m_h(n) || bus.y !== m_v(n)) begin
        errors++; $display("FAIL frame_xy n=%0d got=%0d,%0d exp=%0d,%0d", n, bus.x, bus.y, m_h(n), m_v(n));
      end
      checks++;
      if (bus.frame_start !== (n == 0 || n == FRAME)) begin
        errors++; $display("FAIL frame_start n=%0d got=%b", n, bus.frame_start);
      end
      checks++;
      if (bus.frame_count !== ((n >= FRAME) ? 16'd1 : 16'd0)) begin
        errors++; $display("FAIL frame_count n=%0d got=%0d", n, bus.frame_count);
      end
      checks++;
      if (bus.video_on !== m_von(n)) begin
        errors++; $display("FAIL frame_video_on n=%0d got=%b exp=%b", n, bus.video_on, m_von(n));
      end
    end
    checks++; if (starts !== 2) begin errors++; $display("FAIL frame_start_count got=%0d exp=2", starts); end
  endtask

  task automatic test_syncs();
    int   fall1 = -1, fall2 = -1, vfall = -1, hlow0 = 0, vlow = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    do_reset();
    for (int i = 0; i <= FRAME + P; i++) begin
      if (i > 0) step();
      checks++;
      if (bus.hsync !== m_hs(n - P)) begin
        errors++; $display("FAIL hsync n=%0d got=%b exp=%b", n, bus.hsync, m_hs(n - P));
      end
      checks++;
      if (bus.vsync !== m_vs(n - P)) begin
        errors++; $display("FAIL vsync n=%0d got=%b exp=%b", n, bus.vsync, m_vs(n - P));
      end
      if (prev_hs === 1'b1 && bus.hsync === 1'b0) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      if (prev_vs === 1'b1 && bus.vsync === 1'b0 && vfall < 0) vfall = n;
      if (n < HT && bus.hsync === 1'b0) hlow0++;
      if (bus.vsync === 1'b0) vlow++;
      prev_hs = bus.hsync;
      prev_vs = bus.vsync;
    end
    checks++; if (fall1 !== 12) begin errors++; $display("FAIL hsync_first_fall got=%0d exp=12", fall1); end
    checks++; if (fall2 !== 28) begin errors++; $display("FAIL hsync_period got=%0d exp=28", fall2); end
    checks++; if (hlow0 !== 3) begin errors++; $display("FAIL hsync_width got=%0d exp=3", hlow0); end
    checks++; if (vfall !== 114) begin errors++; $display("FAIL vsync_first_fall got=%0d exp=114", vfall); end
    checks++; if (vlow !== 32) begin errors++; $display("FAIL vsync_width got=%0d exp=32", vlow); end
  endtask

  task automatic test_blank();
    int          lit = 0;
    logic [11:0] prev_rgb = 12'h000;
    logic [11:0] exp_rgb;
    do_reset();
    bus.rgb_in = 12'hFFF;
    for (int i = 0; i < 2 * FRAME + P; i++) begin
      if (i > 0) begin
        prev_rgb = bus.rgb_in;
        step();
      end
      exp_rgb = m_von(n - P) ? prev_rgb : 12'h000;
      checks++;
      if (bus.vga_rgb !== exp_rgb) begin
        errors++; $display("FAIL blank_rgb n=%0d got=%h exp=%h", n, bus.vga_rgb, exp_rgb);
      end
      if (n < FRAME + P && bus.vga_rgb !== 12'h000) lit++;
      // Second frame: arbitrary non-zero colours must still be blanked outside the window.
      bus.rgb_in = (n >= FRAME) ? (12'($urandom) | 12'h001) : 12'hFFF;
    end
    checks++; if (lit !== 48) begin errors++; $display("FAIL blank_lit_pixels got=%0d exp=48", lit); end
  endtask

  task automatic test_pixel_align();
    int          rel;
    logic [11:0] exp_rgb;
    do_reset();
    bus.rgb_in = 12'h000;
    for (int i = 0; i < 2 * HT + P; i++) begin
      if (i > 0) step();
      rel = (n - P) % HT;
      exp_rgb = (n >= P && rel < HA) ? 12'(rel) : 12'h000;
      checks++;
      if (bus.vga_rgb !== exp_rgb) begin
        errors++; $display("FAIL pixel_align n=%0d got=%h exp=%h", n, bus.vga_rgb, exp_rgb);
      end
      bus.rgb_in = 12'(m_h(n - 1 < 0 ? 0 : n - 1));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.rgb_in = 12'hABC;
    while (n < HT + 4) step();
    checks++; if (bus.vga_rgb !== 12'hABC) begin errors++; $display("FAIL mid_active_rgb got=%h exp=abc", bus.vga_rgb); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.vga_rgb !== 12'h000) begin errors++; $display("FAIL async_rgb got=%h exp=000", bus.vga_rgb); end
    checks++; if (bus.x !== 10'd0 || bus.y !== 10'd0) begin errors++; $display("FAIL async_xy got=%0d,%0d exp=0,0", bus.x, bus.y); end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    #1;

    while (n < FRAME + 140) step();
    checks++; if (bus.frame_count !== 16'd1) begin errors++; $display("FAIL mid_frame_count got=%0d exp=1", bus.frame_count); end
    checks++; if (bus.hsync !== 1'b0 || bus.vsync !== 1'b0) begin errors++; $display("FAIL mid_syncs_low got=%b%b exp=00", bus.hsync, bus.vsync); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin errors++; $display("FAIL async_syncs got=%b%b exp=11", bus.hsync, bus.vsync); end
    checks++; if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL async_frame_count got=%0d exp=0", bus.frame_count); end
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    #1;
    checks++; if (bus.x !== 10'd0 || bus.y !== 10'd0 || bus.frame_count !== 16'd0) begin
      errors++; $display("FAIL post_rel got=%0d,%0d,%0d exp=0,0,0", bus.x, bus.y, bus.frame_count);
    end
    for (int i = 0; i < 11; i++) begin
      step();
      checks++;
      if (bus.hsync !== 1'b1 || bus.vsync !== 1'b1) begin
        errors++; $display("FAIL post_rel_no_pulse n=%0d got=%b%b exp=11", n, bus.hsync, bus.vsync);
      end
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_fc;
    do_reset();
    bus.rgb_in = 12'h000;
    while (n < FRAME - 5) step();
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    #1;
    checks++; if (bus.frame_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffff", bus.frame_count); end
    while (n < FRAME + 3) begin
      step();
      exp_fc = (n < FRAME) ? 16'hFFFF : 16'h0000;
      checks++;
      if (bus.frame_count !== exp_fc) begin
        errors++; $display("FAIL wrap_count n=%0d got=%h exp=%h", n, bus.frame_count, exp_fc);
      end
      checks++;
      if (bus.x !== m_h(n) || bus.y !== m_v(n) || bus.video_on !== m_von(n) ||
          bus.hsync !== m_hs(n - P) || bus.vsync !== m_vs(n - P)) begin
        errors++; $display("FAIL wrap_glitch n=%0d got=%0d,%0d,%b,%b,%b", n, bus.x, bus.y, bus.video_on, bus.hsync, bus.vsync);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rgb_in = 12'h000;
    test_reset();
    test_frame();
    test_syncs();
    test_blank();
    test_pixel_align();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch; H_TOTAL = sum of the four = 800.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, in lines; V_TOTAL = 525.
REQ-007 Parameter PIPE_DLY, default 1, range 1..4, sync/blank delay in clocks relative to x/y.
REQ-008 There SHALL be one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-009 clk  input  1  25 MHz pixel clock, all state on rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 rgb_in  input  12  colour for the pixel issued PIPE_DLY-1 clocks earlier (from the colour mux).
REQ-012 x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-013 y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-014 video_on  output  1  high when x<H_ACTIVE and y<V_ACTIVE (undelayed).
REQ-015 frame_start  output  1  high for exactly the cycle where x=0 and y=0.
REQ-016 frame_count  output  16  completed-frame counter.
REQ-017 hsync, vsync  output  1 each  active-low syncs, delayed PIPE_DLY clocks.
REQ-018 vga_rgb  output  12  registered, blanked pixel colour for the DAC pins.

Function
REQ-019 h_cnt SHALL increment every clock and wrap from H_TOTAL-1 to 0; v_cnt SHALL increment only on that wrap and wrap from V_TOTAL-1 to 0.
REQ-020 x, y, video_on, frame_start SHALL be combinational from registered h_cnt/v_cnt (zero latency).
REQ-021 Raw hsync SHALL be low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), high otherwise.
REQ-022 Raw vsync SHALL be low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), high otherwise, for the full line width.
REQ-023 hsync, vsync and an internal delayed video_on SHALL pass through a PIPE_DLY-stage shift register; output at cycle t equals raw value from counters at t-PIPE_DLY.
REQ-024 vga_rgb SHALL register each clock: rgb_in if delayed video_on (PIPE_DLY-1 stages as seen at input) is high, else 12'h000, so vga_rgb is aligned with hsync/vsync.
REQ-025 frame_count SHALL increment by 1 on the clock where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; it wraps 65535 -> 0 silently.
REQ-026 No colour SHALL ever reach vga_rgb during blanking, regardless of rgb_in.
REQ-027 Parameter violations (PIPE_DLY out of range, totals exceeding 1023) SHALL be flagged by elaboration assertion, not handled at runtime.

Reset
REQ-028 While reset is high: h_cnt=0, v_cnt=0, frame_count=0, all delay stages = inactive (hsync=1, vsync=1, blank), vga_rgb=12'h000.
REQ-029 Consequently x=0, y=0, video_on=1, frame_start=1 while reset is held and in the first cycle after release.
REQ-030 Reset asserted mid-line or mid-frame SHALL take effect immediately (asynchronously) and restart timing from (0,0) on release; no partial sync pulse persists.

Verification
REQ-031 Release reset, run 800x525 clocks -> frame_start exactly once at cycle 0 and once at cycle 420000, frame_count=1 at cycle 420000.
REQ-032 Count clocks per line -> hsync low 96 clocks starting PIPE_DLY clocks after x=656, period 800; vsync low 1600 clocks starting PIPE_DLY clocks after (x=0, y=490).
REQ-033 Hold rgb_in=12'hFFF constantly -> vga_rgb=12'hFFF only in 640x480 window (shifted PIPE_DLY clocks), 12'h000 elsewhere; 307200 non-zero pixels per frame.
REQ-034 Drive rgb_in=x[11:0] with PIPE_DLY=1 -> vga_rgb at first visible pixel of each line is 12'h000, then 1, 2, ... 639, aligned with delayed video_on.
REQ-035 Assert reset at x=700, y=491 (during both syncs) -> hsync, vsync go 1 and vga_rgb 0 asynchronously; after release x=0, y=0, frame_count=0.
REQ-036 Force frame_count near 65535 (run or preload via backdoor) -> next frame wrap yields 0 with no glitch on other outputs.
